// File: rtl/sap_controller.sv
// SAP-style controller-sequencer: six-state one-hot ring (T1..T6) advancing on the
// falling clock edge, combinational control word, latched halt. Build option CS_EARLY_END_EN.
module sap_controller (
  input  logic       clk,
  input  logic       clr,
  input  logic [3:0] op,
  output logic [5:0] t,
  output logic       cp,
  output logic       ep,
  output logic       lm,
  output logic       ce,
  output logic       li,
  output logic       ei,
  output logic       la,
  output logic       ea,
  output logic       su,
  output logic       eu,
  output logic       lb,
  output logic       lo,
  output logic       hlt
);

  // state | meaning
  // T1    | address state: PC onto bus, MAR load
  // T2    | increment state: PC increment
  // T3    | memory state: RAM onto bus, IR load
  // T4    | execute 1: operand address fetch or output transfer; HLT latches here
  // T5    | execute 2: operand read into A or B; frozen here while halted
  // T6    | execute 3: ALU result into A
  localparam logic [5:0] T1 = 6'b000001;
  localparam logic [5:0] T2 = 6'b000010;
  localparam logic [5:0] T3 = 6'b000100;
  localparam logic [5:0] T4 = 6'b001000;
  localparam logic [5:0] T5 = 6'b010000;
  localparam logic [5:0] T6 = 6'b100000;

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  logic [5:0] state;
  logic [5:0] state_next;
  logic       halt;
  logic       halt_next;

  logic is_lda;
  logic is_add;
  logic is_sub;
  logic is_out;
  logic is_hlt;
  logic is_nop;

  assign is_lda = (op == OP_LDA);
  assign is_add = (op == OP_ADD);
  assign is_sub = (op == OP_SUB);
  assign is_out = (op == OP_OUT);
  assign is_hlt = (op == OP_HLT);
  assign is_nop = !(is_lda || is_add || is_sub || is_out || is_hlt);

  always_comb begin
    state_next = T1;
    halt_next  = halt;
    if (halt) begin
      state_next = state;
    end else begin
      case (state)
        T1: state_next = T2;
        T2: state_next = T3;
        T3: state_next = T4;
        T4: begin
          state_next = T5;
          if (is_hlt) begin
            halt_next = 1'b1;
          end
`ifdef CS_EARLY_END_EN
          if (is_out || is_nop) begin
            state_next = T1;
          end
`endif
        end
        T5: begin
          state_next = T6;
`ifdef CS_EARLY_END_EN
          if (is_lda) begin
            state_next = T1;
          end
`endif
        end
        T6:      state_next = T1;
        // any non-one-hot value recovers to the start of a fetch
        default: state_next = T1;
      endcase
    end
  end

  always_ff @(negedge clk or posedge clr) begin
    if (clr) begin
      state <= T1;
      halt  <= 1'b0;
    end else begin
      state <= state_next;
      halt  <= halt_next;
    end
  end

  always_comb begin
    cp = 1'b0;
    ep = 1'b0;
    lm = 1'b0;
    ce = 1'b0;
    li = 1'b0;
    ei = 1'b0;
    la = 1'b0;
    ea = 1'b0;
    su = 1'b0;
    eu = 1'b0;
    lb = 1'b0;
    lo = 1'b0;
    if (!halt) begin
      case (state)
        T1: begin
          ep = 1'b1;
          lm = 1'b1;
        end
        T2: cp = 1'b1;
        T3: begin
          ce = 1'b1;
          li = 1'b1;
        end
        T4: begin
          if (is_lda || is_add || is_sub) begin
            ei = 1'b1;
            lm = 1'b1;
          end else if (is_out) begin
            ea = 1'b1;
            lo = 1'b1;
          end
        end
        T5: begin
          if (is_lda) begin
            ce = 1'b1;
            la = 1'b1;
          end else if (is_add || is_sub) begin
            ce = 1'b1;
            lb = 1'b1;
          end
        end
        T6: begin
          if (is_add || is_sub) begin
            su = is_sub;
            eu = 1'b1;
            la = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign t   = state;
  assign hlt = halt;

endmodule

// File: tb/tb_sap_controller.sv
// Directed self-checking bench for sap_controller; expected control words are
// hand-encoded as {cp,ep,lm,ce,li,ei,la,ea,su,eu,lb,lo}.
module tb_sap_controller;

  logic       clk;
  logic       clr;
  logic [3:0] op;
  logic [5:0] t;
  logic cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo, hlt;

  int total;
  int bad;

  localparam logic [11:0] W_CP = 12'h800;
  localparam logic [11:0] W_EP = 12'h400;
  localparam logic [11:0] W_LM = 12'h200;
  localparam logic [11:0] W_CE = 12'h100;
  localparam logic [11:0] W_LI = 12'h080;
  localparam logic [11:0] W_EI = 12'h040;
  localparam logic [11:0] W_LA = 12'h020;
  localparam logic [11:0] W_EA = 12'h010;
  localparam logic [11:0] W_SU = 12'h008;
  localparam logic [11:0] W_EU = 12'h004;
  localparam logic [11:0] W_LB = 12'h002;
  localparam logic [11:0] W_LO = 12'h001;

  localparam logic [11:0] WD_T1 = W_EP | W_LM;
  localparam logic [11:0] WD_T2 = W_CP;
  localparam logic [11:0] WD_T3 = W_CE | W_LI;

`ifdef CS_EARLY_END_EN
  localparam int LEN_LDA = 5;
  localparam int LEN_OUT = 4;
  localparam int LEN_NOP = 4;
`else
  localparam int LEN_LDA = 6;
  localparam int LEN_OUT = 6;
  localparam int LEN_NOP = 6;
`endif
  localparam int LEN_ALU = 6;

  logic [11:0] word;
  assign word = {cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo};

  sap_controller dut (
    .clk(clk), .clr(clr), .op(op), .t(t),
    .cp(cp), .ep(ep), .lm(lm), .ce(ce), .li(li), .ei(ei),
    .la(la), .ea(ea), .su(su), .eu(eu), .lb(lb), .lo(lo), .hlt(hlt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic fall();
    @(negedge clk);
    #1;
  endtask

  task automatic start_t1(input logic [3:0] opcode);
    op  = opcode;
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
  endtask

  task automatic test_reset_power_on();
    op  = 4'b0000;
    clr = 1'b1;
    #3;
    total++;
    if (t !== 6'b000001) begin bad++; $display("FAIL por_t: got %b want 000001", t); end
    total++;
    if (word !== WD_T1) begin bad++; $display("FAIL por_word: got %h want %h", word, WD_T1); end
    total++;
    if (hlt !== 1'b0) begin bad++; $display("FAIL por_hlt: got %b want 0", hlt); end
    @(posedge clk);
    #1;
    clr = 1'b0;
  endtask

  task automatic test_lda();
    logic [11:0] exp [6];
    exp[0] = WD_T1; exp[1] = WD_T2; exp[2] = WD_T3;
    exp[3] = W_EI | W_LM; exp[4] = W_CE | W_LA; exp[5] = 12'h000;
    start_t1(4'b0000);
    for (int k = 0; k < LEN_LDA; k++) begin
      total++;
      if (t !== 6'(1 << k)) begin bad++; $display("FAIL lda_t%0d: got %b want %b", k + 1, t, 6'(1 << k)); end
      total++;
      if (word !== exp[k]) begin bad++; $display("FAIL lda_word_t%0d: got %h want %h", k + 1, word, exp[k]); end
      fall();
    end
    total++;
    if (t !== 6'b000001) begin bad++; $display("FAIL lda_wrap: got %b want 000001 after %0d clocks", t, LEN_LDA); end
  endtask

  task automatic test_add_sub();
    logic [11:0] exp_add [6];
    logic [11:0] exp_sub [6];
    exp_add[0] = WD_T1; exp_add[1] = WD_T2; exp_add[2] = WD_T3;
    exp_add[3] = W_EI | W_LM; exp_add[4] = W_CE | W_LB; exp_add[5] = W_EU | W_LA;
    exp_sub[0] = WD_T1; exp_sub[1] = WD_T2; exp_sub[2] = WD_T3;
    exp_sub[3] = W_EI | W_LM; exp_sub[4] = W_CE | W_LB; exp_sub[5] = W_SU | W_EU | W_LA;
    start_t1(4'b0010);
    for (int k = 0; k < LEN_ALU; k++) begin
      total++;
      if (word !== exp_sub[k]) begin bad++; $display("FAIL sub_word_t%0d: got %h want %h", k + 1, word, exp_sub[k]); end
      fall();
    end
    total++;
    if (t !== 6'b000001) begin bad++; $display("FAIL sub_wrap: got %b want 000001", t); end
    // ADD follows SUB back to back; op changes while in T1, where it is don't-care
    op = 4'b0001;
    for (int k = 0; k < LEN_ALU; k++) begin
      total++;
      if (word !== exp_add[k]) begin bad++; $display("FAIL add_word_t%0d: got %h want %h", k + 1, word, exp_add[k]); end
      fall();
    end
    total++;
    if (t !== 6'b000001) begin bad++; $display("FAIL add_wrap: got %b want 000001", t); end
  endtask

  task automatic test_back_to_back();
    // OUT immediately followed by NOP without an intervening clr
    start_t1(4'b1110);
    for (int k = 0; k < LEN_OUT; k++) begin
      if (k == 3) begin
        total++;
        if (word !== (W_EA | W_LO)) begin bad++; $display("FAIL out_t4: got %h want %h", word, W_EA | W_LO); end
      end
      if (k > 3) begin
        total++;
        if (word !== 12'h000) begin bad++; $display("FAIL out_t%0d: got %h want 000", k + 1, word); end
      end
      fall();
    end
    total++;
    if (t !== 6'b000001) begin bad++; $display("FAIL out_wrap: got %b want 000001 after %0d clocks", t, LEN_OUT); end
    op = 4'b0101;
    for (int k = 0; k < LEN_NOP; k++) begin
      total++;
      if (t !== 6'(1 << k)) begin bad++; $display("FAIL nop_t%0d: got %b want %b", k + 1, t, 6'(1 << k)); end
      if (k >= 3) begin
        total++;
        if (word !== 12'h000) begin bad++; $display("FAIL nop_word_t%0d: got %h want 000", k + 1, word); end
      end
      fall();
    end
    total++;
    if (t !== 6'b000001) begin bad++; $display("FAIL nop_wrap: got %b want 000001 after %0d clocks", t, LEN_NOP); end
  endtask

  task automatic test_hlt();
    start_t1(4'b1111);
    fall(); fall(); fall();
    total++;
    if (t !== 6'b001000 || word !== 12'h000 || hlt !== 1'b0) begin
      bad++; $display("FAIL hlt_t4: got t=%b word=%h hlt=%b want t=001000 word=000 hlt=0", t, word, hlt);
    end
    fall();
    total++;
    if (hlt !== 1'b1) begin bad++; $display("FAIL hlt_flag: got %b want 1", hlt); end
    total++;
    if (t !== 6'b010000) begin bad++; $display("FAIL hlt_t: got %b want 010000", t); end
    total++;
    if (word !== 12'h000) begin bad++; $display("FAIL hlt_word: got %h want 000", word); end
    op = 4'b0001;
    for (int k = 0; k < 10; k++) begin
      fall();
      total++;
      if (t !== 6'b010000 || hlt !== 1'b1 || word !== 12'h000) begin
        bad++; $display("FAIL hlt_hold%0d: got t=%b hlt=%b word=%h want t=010000 hlt=1 word=000", k, t, hlt, word);
      end
    end
    #2;
    clr = 1'b1;
    #1;
    total++;
    if (t !== 6'b000001 || hlt !== 1'b0 || word !== WD_T1) begin
      bad++; $display("FAIL hlt_clr: got t=%b hlt=%b word=%h want t=000001 hlt=0 word=%h", t, hlt, word, WD_T1);
    end
    @(posedge clk);
    #1;
    clr = 1'b0;
  endtask

  task automatic test_reset_mid();
    start_t1(4'b0001);
    fall(); fall(); fall();
    total++;
    if (t !== 6'b001000) begin bad++; $display("FAIL mid_pre_t: got %b want 001000", t); end
    #2;
    clr = 1'b1;
    #1;
    total++;
    if (t !== 6'b000001) begin bad++; $display("FAIL mid_t: got %b want 000001", t); end
    total++;
    if (word !== WD_T1) begin bad++; $display("FAIL mid_word: got %h want %h", word, WD_T1); end
    total++;
    if (hlt !== 1'b0) begin bad++; $display("FAIL mid_hlt: got %b want 0", hlt); end
  endtask

  task automatic test_reset_release();
    clr = 1'b1;
    fall();
    total++;
    if (t !== 6'b000001) begin bad++; $display("FAIL rel_hold_clr: got %b want 000001", t); end
    @(posedge clk);
    #1;
    clr = 1'b0;
    #2;
    total++;
    if (t !== 6'b000001) begin bad++; $display("FAIL rel_before_edge: got %b want 000001", t); end
    fall();
    total++;
    if (t !== 6'b000010) begin bad++; $display("FAIL rel_first_edge: got %b want 000010", t); end
    total++;
    if (word !== WD_T2) begin bad++; $display("FAIL rel_word: got %h want %h", word, WD_T2); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    clr   = 1'b1;
    op    = 4'b0000;
    test_reset_power_on();
    test_lda();
    test_add_sub();
    test_back_to_back();
    test_hlt();
    test_reset_mid();
    test_reset_release();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
